// File: rtl/mux_arb_reg.sv
// mux_arb_reg: N-channel, W-bit registered multiplexer with valid/ready handshake.
//   mode 0 forwards the channel chosen by sel; mode 1 round-robin arbitrates
//   among valid channels. One output register stage, full throughput.
//   Optional feature macro: MUX_LOCK_EN (adds in_last, lets a mode-1 burst hold
//   the arbiter until its last beat).
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset
//   in_data    in   CHANNELS*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid   in   per-channel valid
//   in_ready   out  per-channel ready, one-hot or zero (combinational)
//   in_last    in   per-channel last-beat flag (MUX_LOCK_EN only)
//   sel        in   channel select for mode 0
//   mode       in   0 = explicit select, 1 = round-robin
//   out        out  registered data word
//   out_chan   out  source channel of out
//   out_valid  out  out holds a word
//   out_ready  in   downstream accepts out
module mux_arb_reg #(
    parameter int unsigned WIDTH    = 24,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [CHANNELS*WIDTH-1:0]    in_data,
    input  logic [CHANNELS-1:0]          in_valid,
    output logic [CHANNELS-1:0]          in_ready,
`ifdef MUX_LOCK_EN
    input  logic [CHANNELS-1:0]          in_last,
`endif
    input  logic [$clog2(CHANNELS)-1:0]  sel,
    input  logic                         mode,
    output logic [WIDTH-1:0]             out,
    output logic [$clog2(CHANNELS)-1:0]  out_chan,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int unsigned SEL_W = $clog2(CHANNELS);

    logic [WIDTH-1:0] chan_data [CHANNELS];
    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] g;
    logic [SEL_W-1:0] cand;
    logic             grant;
    logic             ld;
    logic             xfer;
    logic             lock_active;

    // Unpack the flat input bus into per-channel words.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
        assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
    end

`ifdef MUX_LOCK_EN
    logic locked;
    // While locked, last already holds the locked channel.
    assign lock_active = locked;
`else
    assign lock_active = 1'b0;
`endif

    assign ld   = !out_valid || out_ready;
    assign xfer = ld && grant;

    // Grant selection: explicit select, held lock, or rotating scan from last+1.
    always_comb begin
        grant = 1'b0;
        g     = '0;
        cand  = '0;
        if (!mode) begin
            if ((32'(sel) < CHANNELS) && in_valid[sel]) begin
                grant = 1'b1;
                g     = sel;
            end
        end else if (lock_active) begin
            g     = last;
            grant = in_valid[last];
        end else begin
            for (int unsigned k = 1; k <= CHANNELS; k++) begin
                cand = SEL_W'((32'(last) + k) % CHANNELS);
                if (!grant && in_valid[cand]) begin
                    grant = 1'b1;
                    g     = cand;
                end
            end
        end
    end

    // Ready goes only to the granted channel, and only when the output can load.
    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[g] = 1'b1;
        end
    end

    // Output register stage and round-robin pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            out       <= '0;
            out_chan  <= '0;
            out_valid <= 1'b0;
            last      <= SEL_W'(CHANNELS - 1);
        end else if (ld) begin
            if (xfer) begin
                out       <= chan_data[g];
                out_chan  <= g;
                out_valid <= 1'b1;
                if (mode) begin
                    last <= g;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef MUX_LOCK_EN
    // Burst lock: a non-last mode-1 beat locks onto its channel; mode 0 clears it.
    always_ff @(posedge clock) begin
        if (reset || !mode) begin
            locked <= 1'b0;
        end else if (xfer) begin
            locked <= !in_last[g];
        end
    end
`endif

endmodule

// File: tb/tb_mux_arb_reg.sv
// tb_mux_arb_reg: directed stimulus with a scoreboard queue; a monitor pops
// and compares each output word as downstream accepts it.
module tb_mux_arb_reg;

    localparam int unsigned WIDTH    = 24;
    localparam int unsigned CHANNELS = 4;

    logic                      clock;
    logic                      reset;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [CHANNELS-1:0]       in_last;
    logic [1:0]                sel;
    logic                      mode;
    logic [WIDTH-1:0]          out;
    logic [1:0]                out_chan;
    logic                      out_valid;
    logic                      out_ready;

    int checks   = 0;
    int failures = 0;

    logic [25:0] exp_q [$];
    logic [23:0] chd [4];

    mux_arb_reg #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef MUX_LOCK_EN
        .in_last   (in_last),
`endif
        .sel       (sel),
        .mode      (mode),
        .out       (out),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_data();
        for (int i = 0; i < 4; i++) begin
            in_data[i*WIDTH +: WIDTH] = chd[i];
        end
    endtask

    task automatic push(input int ch);
        exp_q.push_back({chd[ch], 2'(ch)});
    endtask

    // Monitor: a word is consumed when out_valid & out_ready hold at the edge.
    initial begin
        logic [25:0] e;
        forever begin
            @(negedge clock);
            if (out_valid && out_ready && !reset) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got %h/%0d expected none", out, out_chan);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", 32'(out), 32'(e[25:2]));
                    check("word_chan", 32'(out_chan), 32'(e[1:0]));
                end
            end
        end
    end

    initial begin
        chd[0] = 24'h100001;
        chd[1] = 24'h200002;
        chd[2] = 24'hABCDEF;
        chd[3] = 24'h400004;
        in_data   = '0;
        set_data();
        in_valid  = '0;
        in_last   = '1;
        sel       = '0;
        mode      = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        step();
        step();
        check("rst_out", 32'(out), 32'h0);
        check("rst_chan", 32'(out_chan), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        reset = 1'b0;

        // Mode 0 explicit select of channel 2.
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
        #1;
        check("m0_in_ready", 32'(in_ready), 32'b0100);
        push(2);
        step();
        check("m0_out", 32'(out), 32'hABCDEF);
        check("m0_valid", 32'(out_valid), 32'h1);

        // Mode 0 select of an idle channel: no grant, output drains.
        sel = 2'd1;
        #1;
        check("m0_idle_ready", 32'(in_ready), 32'h0);
        step();
        check("m0_idle_valid", 32'(out_valid), 32'h0);
        check("m0_idle_hold", 32'(out), 32'hABCDEF);

        // Mode 1 round robin, all valid: 0,1,2,3,0,1.
        mode = 1'b1; in_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            push(k % 4);
            step();
            check("rr_valid", 32'(out_valid), 32'h1);
            check("rr_chan", 32'(out_chan), 32'(k % 4));
        end

        // Backpressure for 3 cycles.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'h0);
            check("bp_out", 32'(out), 32'h200002);
            check("bp_chan", 32'(out_chan), 32'h1);
            check("bp_valid", 32'(out_valid), 32'h1);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'b0100);
        push(2);
        step();
        check("bp_reload_chan", 32'(out_chan), 32'h2);
        check("bp_reload_valid", 32'(out_valid), 32'h1);

        // Reset while a word is held: the word is discarded.
        out_ready = 1'b0; in_valid = '0; reset = 1'b1;
        void'(exp_q.pop_back());
        step();
        reset = 1'b0;
        check("rst2_valid", 32'(out_valid), 32'h0);
        check("rst2_out", 32'(out), 32'h0);
        check("rst2_chan", 32'(out_chan), 32'h0);
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        #1;
        check("rst2_first_grant", 32'(in_ready), 32'b0001);
        push(0);
        step();
        in_valid = '0;
        step();
        check("idle_valid", 32'(out_valid), 32'h0);

`ifdef MUX_LOCK_EN
        // Burst lock: ch1 sends 3 beats (last on the third) while ch2 waits.
        in_valid = 4'b0110;
        for (int b = 0; b < 3; b++) begin
            chd[1] = 24'h200010 + 24'(b);
            set_data();
            in_last[1] = (b == 2);
            #1;
            check("lock_in_ready", 32'(in_ready), 32'b0010);
            push(1);
            step();
            check("lock_chan", 32'(out_chan), 32'h1);
        end
        #1;
        check("unlock_in_ready", 32'(in_ready), 32'b0100);
        push(2);
        step();
        check("unlock_chan", 32'(out_chan), 32'h2);
        in_valid = '0;
`endif

        // Drain: every queued word must have been seen.
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            step();
        end
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
